i2s_tx_ctrl: RTL

- Master-mode I2S transmit controller and sequencer.
- Divides the system clock to produce bclk and ws, fetches stereo sample pairs over a valid/ready stream into a one-deep shadow buffer, and serialises them MSB-first in standard I2S (one-bclk-delayed) format.
- Sits between the audio sample source and the codec pins.

---
 rtl/i2s_tx_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_ctrl.sv
// Master-mode I2S transmit controller: divides clk into bclk/ws, holds one stereo
// pair in a shadow buffer and serialises each frame MSB-first, one bclk after ws.
module i2s_tx_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata_l,
  input  logic [DATA_W-1:0] s_tdata_r,
  output logic              bclk,
  output logic              ws,
  output logic              sdata,
  output logic              underflow,
  output logic              busy
);

  localparam int FRAME = 2 * SLOT_W;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int B_W   = $clog2(FRAME);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [B_W-1:0]      b_q, b_d;
  logic                bclk_q, bclk_d;
  logic                ws_q, ws_d;
  logic                sdata_q, sdata_d;
  logic                underflow_q, underflow_d;
  logic                shadowFull_q, shadowFull_d;
  logic [DATA_W-1:0]   shadowL_q, shadowL_d;
  logic [DATA_W-1:0]   shadowR_q, shadowR_d;
  logic [DATA_W-1:0]   txL_q, txL_d;
  logic [DATA_W-1:0]   txR_q, txR_d;

  logic                frameLoad;
  logic                handshake;
  logic [DATA_W-1:0]   shiftedWord;
  int                  bIdx;

  assign s_tready  = !shadowFull_q;
  assign handshake = s_tvalid && !shadowFull_q;
  assign bclk      = bclk_q;
  assign ws        = ws_q;
  assign sdata     = sdata_q;
  assign underflow = underflow_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    b_d          = b_q;
    bclk_d       = bclk_q;
    ws_d         = 1'b0;
    sdata_d      = 1'b0;
    underflow_d  = 1'b0;
    shadowFull_d = shadowFull_q;
    shadowL_d    = shadowL_q;
    shadowR_d    = shadowR_q;
    txL_d        = txL_q;
    txR_d        = txR_q;
    frameLoad    = 1'b0;
    shiftedWord  = '0;
    bIdx         = 0;

    case (state_q)
      IDLE: begin
        div_d  = '0;
        b_d    = '0;
        bclk_d = 1'b0;
        if (enable) begin
          state_d   = RUN;
          frameLoad = 1'b1;
        end
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          // The bit index only moves on bclk falling events.
          if (bclk_q) begin
            if (b_q == B_LAST) begin
              b_d = '0;
              if (enable) begin
                frameLoad = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              b_d = b_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frameLoad) begin
      if (shadowFull_q) begin
        txL_d        = shadowL_q;
        txR_d        = shadowR_q;
        shadowFull_d = 1'b0;
      end else if (handshake) begin
        txL_d = s_tdata_l;
        txR_d = s_tdata_r;
      end else begin
        txL_d       = '0;
        txR_d       = '0;
        underflow_d = 1'b1;
      end
    end else if (handshake) begin
      shadowL_d    = s_tdata_l;
      shadowR_d    = s_tdata_r;
      shadowFull_d = 1'b1;
    end

    // Outputs track the index and words being applied this cycle.
    if (state_d == RUN) begin
      bIdx = int'(b_d);
      ws_d = (bIdx >= SLOT_W - 1) && (bIdx <= FRAME - 2);
      if (bIdx < DATA_W) begin
        shiftedWord = txL_d >> (DATA_W - 1 - bIdx);
        sdata_d     = shiftedWord[0];
      end else if ((bIdx >= SLOT_W) && (bIdx < SLOT_W + DATA_W)) begin
        shiftedWord = txR_d >> (DATA_W - 1 - (bIdx - SLOT_W));
        sdata_d     = shiftedWord[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      b_q          <= '0;
      bclk_q       <= 1'b0;
      ws_q         <= 1'b0;
      sdata_q      <= 1'b0;
      underflow_q  <= 1'b0;
      shadowFull_q <= 1'b0;
      shadowL_q    <= '0;
      shadowR_q    <= '0;
      txL_q        <= '0;
      txR_q        <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      b_q          <= b_d;
      bclk_q       <= bclk_d;
      ws_q         <= ws_d;
      sdata_q      <= sdata_d;
      underflow_q  <= underflow_d;
      shadowFull_q <= shadowFull_d;
      shadowL_q    <= shadowL_d;
      shadowR_q    <= shadowR_d;
      txL_q        <= txL_d;
      txR_q        <= txR_d;
    end
  end

endmodule
